// File: rtl/uart_pkg.sv
// Shared UART transmit types and line constants.
// No logic of its own; imported by the serialiser files.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Bit counter must hold DATA_W-1 and STOP_BITS-1 without wrapping.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load shift register presenting the next bit to send on q_bit.
// Load wins over shift; q_bit is the end bit in the selected direction.
module piso_shift #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              q_bit
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = (LSB_FIRST != 0) ? {1'b0, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_bit = (LSB_FIRST != 0) ? sr_q[0] : sr_q[DATA_W-1];

endmodule

// File: rtl/piso_frame_tx.sv
// Framed UART serialiser: start, data, optional parity, 1-2 stop bits, paced by tick.
// Accepts a word only in IDLE (in_ready); serial_out is registered, one bit per tick.
module piso_frame_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             serial_out_q, serial_out_d;
  logic             done_q, done_d;
  logic             load;
  logic             shift;
  logic             q_bit;

  // The register shifts on the tick that starts each data bit, so q_bit
  // already holds the following bit when the next tick arrives.
  piso_shift #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(shift),
    .d    (in_data),
    .q_bit(q_bit)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    parity_d     = parity_q;
    serial_out_d = serial_out_q;
    done_d       = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    case (state_q)
      IDLE: begin
        serial_out_d = LINE_IDLE;
        if (in_valid) begin
          load         = 1'b1;
          parity_d     = (PARITY_ODD != 0) ? ~^in_data : ^in_data;
          cnt_d        = '0;
          state_d      = START;
          serial_out_d = START_BIT;
        end
      end
      START: begin
        if (tick) begin
          shift        = 1'b1;
          serial_out_d = q_bit;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift = 1'b1;
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d      = PARITY;
              serial_out_d = parity_q;
            end else begin
              state_d      = STOP;
              serial_out_d = LINE_IDLE;
            end
          end else begin
            cnt_d        = cnt_q + 1'b1;
            serial_out_d = q_bit;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d      = STOP;
          serial_out_d = LINE_IDLE;
        end
      end
      STOP: begin
        serial_out_d = LINE_IDLE;
        if (tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        serial_out_d = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      parity_q     <= 1'b0;
      serial_out_q <= LINE_IDLE;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      parity_q     <= parity_d;
      serial_out_q <= serial_out_d;
      done_q       <= done_d;
    end
  end

  assign serial_out = serial_out_q;
  assign done       = done_q;
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx: four configurations share clock, tick and reset.
// Accepted words push their expected frame; a monitor rebuilds frames from the line.
module tb_piso_frame_tx;

  logic       clk;
  logic       rst_n;
  logic       tick = 1'b0;
  logic [3:0] iv = '0;
  logic [3:0] rdy, so, bsy, dn;
  logic [7:0] din [4];

  int N = 4;
  int tcnt = 0;
  bit junk_en = 1'b0;

  logic [7:0]  word_q [4][$];
  logic [15:0] exp_q  [4][$];
  bit          real_pend [4];
  bit          acc_s [4];
  bit          acc_junk [4];
  bit          tick_s;

  bit          act [4];
  int          nb  [4];
  int          cyc [4];
  bit          atk [4];
  logic [15:0] got [4];

  int checks = 0;
  int errors = 0;

  piso_frame_tx #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(iv[0]), .in_data(din[0]),
    .in_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]), .done(dn[0]));
  piso_frame_tx #(.DATA_W(8), .LSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(iv[1]), .in_data(din[1]),
    .in_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]), .done(dn[1]));
  piso_frame_tx #(.DATA_W(8), .LSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(iv[2]), .in_data(din[2]),
    .in_ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]), .done(dn[2]));
  piso_frame_tx #(.DATA_W(5), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .in_valid(iv[3]), .in_data(din[3][4:0]),
    .in_ready(rdy[3]), .serial_out(so[3]), .busy(bsy[3]), .done(dn[3]));

  function automatic int cfg_dw(input int i);   return (i == 3) ? 5 : 8; endfunction
  function automatic int cfg_lsb(input int i);  return (i == 1 || i == 2) ? 0 : 1; endfunction
  function automatic int cfg_pen(input int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int cfg_podd(input int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int cfg_stop(input int i); return (i == 3) ? 2 : 1; endfunction

  function automatic int frame_len(input int i);
    return 1 + cfg_dw(i) + cfg_pen(i) + cfg_stop(i);
  endfunction

  // Bit k of the result is the k-th bit on the line.
  function automatic logic [15:0] frame_vec(input int i, input logic [7:0] w);
    logic [15:0] v;
    int k;
    int ones;
    v = '0;
    k = 1;
    ones = 0;
    for (int j = 0; j < cfg_dw(i); j++) begin
      v[k] = (cfg_lsb(i) != 0) ? w[j] : w[cfg_dw(i) - 1 - j];
      ones += int'(w[j]);
      k++;
    end
    if (cfg_pen(i) != 0) begin
      v[k] = ((ones % 2) != cfg_podd(i));
      k++;
    end
    for (int s = 0; s < cfg_stop(i); s++) begin
      v[k] = 1'b1;
      k++;
    end
    return v;
  endfunction

  function automatic string nm(input int i, input string s);
    return $sformatf("u%0d %s", i, s);
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
    checks++;
    if (actual !== expect_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expect_v, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator and per-instance word driver.
  initial begin
    for (int i = 0; i < 4; i++) din[i] = '0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1 >= N) ? 0 : tcnt + 1;
      tick = (tcnt == 0);
      for (int i = 0; i < 4; i++) begin
        if (!rst_n) begin
          iv[i] = 1'b0;
          real_pend[i] = 1'b0;
          word_q[i].delete();
        end else begin
          if (real_pend[i] && acc_s[i]) real_pend[i] = 1'b0;
          if (!real_pend[i]) begin
            if (word_q[i].size() != 0) begin
              din[i] = word_q[i].pop_front();
              iv[i] = 1'b1;
              real_pend[i] = 1'b1;
            end else if (junk_en && bsy[i]) begin
              iv[i] = 1'($urandom_range(0, 1));
              din[i] = 8'($urandom);
            end else begin
              iv[i] = 1'b0;
              din[i] = 8'($urandom);
            end
          end
        end
      end
    end
  end

  // Handshake observer: expected frames enter the scoreboard on acceptance.
  initial begin
    forever begin
      @(posedge clk);
      tick_s = tick;
      for (int i = 0; i < 4; i++) begin
        acc_s[i] = rst_n && iv[i] && rdy[i];
        acc_junk[i] = acc_s[i] && !real_pend[i];
        if (acc_s[i] && real_pend[i]) exp_q[i].push_back(frame_vec(i, din[i]));
      end
    end
  end

  // Line monitor: one bit per tick-delimited interval, compared at done.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!rst_n) begin
          chk(nm(i, "reset serial_out"), so[i], 1);
          chk(nm(i, "reset busy"), bsy[i], 0);
          chk(nm(i, "reset in_ready"), rdy[i], 1);
          chk(nm(i, "reset done"), dn[i], 0);
          act[i] = 1'b0;
          exp_q[i].delete();
        end else if (acc_s[i]) begin
          chk(nm(i, "accepted word while busy"), acc_junk[i], 0);
          act[i] = 1'b1;
          nb[i] = 1;
          got[i] = '0;
          got[i][0] = so[i];
          cyc[i] = 0;
          atk[i] = tick_s;
          chk(nm(i, "busy after accept"), bsy[i], 1);
          chk(nm(i, "in_ready after accept"), rdy[i], 0);
          chk(nm(i, "done after accept"), dn[i], 0);
        end else if (act[i]) begin
          cyc[i]++;
          if (dn[i]) begin
            chk(nm(i, "frames pending at done"), exp_q[i].size(), 1);
            if (exp_q[i].size() != 0) chk(nm(i, "frame bits"), got[i], exp_q[i].pop_front());
            chk(nm(i, "frame length"), nb[i], frame_len(i));
            chk(nm(i, "done serial_out"), so[i], 1);
            chk(nm(i, "done in_ready"), rdy[i], 1);
            chk(nm(i, "done busy"), bsy[i], 0);
            if (atk[i]) chk(nm(i, "accept to done cycles"), cyc[i], frame_len(i) * N);
            act[i] = 1'b0;
          end else begin
            if (tick_s) begin
              if (nb[i] < 16) got[i][nb[i]] = so[i];
              nb[i]++;
            end else if (nb[i] <= 16) begin
              chk(nm(i, "bit held between ticks"), so[i], got[i][nb[i]-1]);
            end
            chk(nm(i, "in_ready mid-frame"), rdy[i], 0);
            chk(nm(i, "busy mid-frame"), bsy[i], 1);
          end
        end else begin
          chk(nm(i, "idle serial_out"), so[i], 1);
          chk(nm(i, "idle done"), dn[i], 0);
          chk(nm(i, "idle in_ready"), rdy[i], 1);
          chk(nm(i, "idle busy"), bsy[i], 0);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    bit idle;
    k = 0;
    idle = 1'b0;
    while (!idle && k < budget) begin
      @(negedge clk);
      #1;
      k++;
      idle = 1'b1;
      for (int i = 0; i < 4; i++)
        if (word_q[i].size() != 0 || real_pend[i] || act[i] || exp_q[i].size() != 0) idle = 1'b0;
    end
    chk("all frames completed", idle, 1);
  endtask

  // Returns just after a negedge such that the next negedge raises tick.
  task automatic align_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (tcnt != N - 1 && k < 100);
  endtask

  task automatic push_all(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
    word_q[0].push_back(w0);
    word_q[1].push_back(w1);
    word_q[2].push_back(w2);
    word_q[3].push_back(w3);
  endtask

  initial begin
    logic [7:0] w8;
    int n;
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Tick-aligned single frames: 8'hC9, 8'h0F (even and odd parity), 5'h15.
    N = 4;
    align_tick();
    push_all(8'hC9, 8'h0F, 8'h0F, 8'h15);
    wait_idle(1000);

    // Back-to-back with in_valid held high.
    align_tick();
    push_all(8'hA5, 8'hA5, 8'hA5, 8'hA5);
    push_all(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    wait_idle(1000);

    // in_valid and in_data wiggled while frames are in flight.
    junk_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      N = $urandom_range(2, 5);
      push_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_idle(1000);
    end
    junk_en = 1'b0;

    // Reset during data bit 3 of instance 0, then recover.
    N = 4;
    align_tick();
    push_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(act[0] && nb[0] == 5) && k < 500);
    chk("reached data bit 3", (act[0] && nb[0] == 5), 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk(nm(i, "async reset serial_out"), so[i], 1);
      chk(nm(i, "async reset busy"), bsy[i], 0);
      chk(nm(i, "async reset in_ready"), rdy[i], 1);
      chk(nm(i, "async reset done"), dn[i], 0);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    push_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wait_idle(1000);

    // Random words, random gaps and bursts, several baud rates.
    for (int r = 0; r < 6; r++) begin
      N = $urandom_range(1, 6);
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i < 4; i++) begin
          n = $urandom_range(0, 2);
          for (int m = 0; m < n; m++) begin
            w8 = 8'($urandom);
            word_q[i].push_back(w8);
          end
        end
        wait_idle(3000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
